// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and UART-FIFO-side signals of the shared transmit arbiter.
// The slave modport is the arbiter; the master modport drives the requesters and the FIFO flag.
interface uart_tx_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int DBIT = 8
);
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      last;
    logic [NREQ*DBIT-1:0] din;
    logic [NREQ-1:0]      ack;
    logic                 tx_full;
    logic                 wr_uart;
    logic [DBIT-1:0]      w_data;
    logic                 busy;
    logic [IDW-1:0]       grant_id;
    logic                 ovf_tick;

    modport master (
        output req, last, din, tx_full,
        input  ack, wr_uart, w_data, busy, grant_id, ovf_tick
    );

    modport slave (
        input  req, last, din, tx_full,
        output ack, wr_uart, w_data, busy, grant_id, ovf_tick
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART tx FIFO write port
// among NREQ byte streams, optionally prefixing each packet with an id tag.
//
// state | meaning
// IDLE  | no owner; pick the next requester after the previous owner
// TAG   | owner granted; writing the tag byte
// DATA  | streaming owner bytes until last or MAX_LEN
module uart_tx_arbiter #(
    parameter int              NREQ     = 4,
    parameter int              IDW      = 2,
    parameter int              DBIT     = 8,
    parameter int              TAG_EN   = 1,
    parameter logic [DBIT-1:0] TAG_BASE = 8'hA0,
    parameter int              MAX_LEN  = 64,
    parameter int              LEN_W    = 7
) (
    input logic              clk,
    input logic              reset,
    uart_tx_arbiter_if.slave arb
);
    typedef enum logic [1:0] {IDLE, TAG, DATA} state_t;

    localparam logic [LEN_W-1:0] MAX_CNT = LEN_W'(MAX_LEN);

    state_t           state, state_nxt;
    logic [IDW-1:0]   grant_id, grant_id_nxt;
    logic [IDW-1:0]   ptr, ptr_nxt;
    logic [IDW-1:0]   winner;
    logic             any_req;
    logic [LEN_W-1:0] cnt, cnt_nxt;
    logic             ovf_tick, ovf_nxt;
    logic             wr;
    logic [DBIT-1:0]  wdata;
    logic [NREQ-1:0]  ack;
    logic [DBIT-1:0]  tag_byte;

    assign tag_byte = {TAG_BASE[DBIT-1:IDW], grant_id};

    // Scan from farthest to nearest so the nearest requester after ptr wins.
    always_comb begin
        any_req = 1'b0;
        winner  = '0;
        for (int k = NREQ; k >= 1; k--) begin
            if (arb.req[(int'(ptr) + k) % NREQ]) begin
                any_req = 1'b1;
                winner  = IDW'((int'(ptr) + k) % NREQ);
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        grant_id_nxt = grant_id;
        ptr_nxt      = ptr;
        cnt_nxt      = cnt;
        ovf_nxt      = 1'b0;
        wr           = 1'b0;
        wdata        = '0;
        ack          = '0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    grant_id_nxt = winner;
                    cnt_nxt      = '0;
                    state_nxt    = (TAG_EN != 0) ? TAG : DATA;
                end
            end
            TAG: begin
                wdata = tag_byte;
                wr    = !arb.tx_full;
                if (wr) state_nxt = DATA;
            end
            DATA: begin
                wdata         = arb.din[int'(grant_id)*DBIT +: DBIT];
                wr            = arb.req[grant_id] & !arb.tx_full;
                ack[grant_id] = wr;
                if (wr) begin
                    cnt_nxt = cnt + 1'b1;
                    // A byte flagged last at exactly MAX_LEN ends normally, no overflow.
                    if (arb.last[grant_id] || cnt_nxt == MAX_CNT) begin
                        ptr_nxt   = grant_id;
                        state_nxt = IDLE;
                        ovf_nxt   = !arb.last[grant_id];
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            grant_id <= '0;
            ptr      <= IDW'(NREQ - 1);
            cnt      <= '0;
            ovf_tick <= 1'b0;
        end else begin
            state    <= state_nxt;
            grant_id <= grant_id_nxt;
            ptr      <= ptr_nxt;
            cnt      <= cnt_nxt;
            ovf_tick <= ovf_nxt;
        end
    end

    assign arb.wr_uart  = wr;
    assign arb.w_data   = wdata;
    assign arb.ack      = ack;
    assign arb.busy     = (state != IDLE);
    assign arb.grant_id = grant_id;
    assign arb.ovf_tick = ovf_tick;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench: packet-level requester sources, a cycle reference model of the
// arbitration rules, directed scenarios and a randomized traffic phase.
module tb_uart_tx_arbiter;
    localparam int              NREQ     = 4;
    localparam int              IDW      = 2;
    localparam int              DBIT     = 8;
    localparam int              TAG_EN   = 1;
    localparam logic [DBIT-1:0] TAG_BASE = 8'hA0;
    localparam int              MAX_LEN  = 4;
    localparam int              LEN_W    = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NREQ(NREQ), .IDW(IDW), .DBIT(DBIT)) bus ();

    uart_tx_arbiter #(
        .NREQ(NREQ), .IDW(IDW), .DBIT(DBIT), .TAG_EN(TAG_EN),
        .TAG_BASE(TAG_BASE), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .arb(bus)
    );

    int total = 0;
    int bad = 0;

    // Per-requester byte sources: {last, byte}
    logic [8:0] src [NREQ][64];
    int         hd [NREQ];
    int         tl [NREQ];
    bit         en [NREQ];
    logic       tx_full_drv;

    logic [7:0] out_log [$];
    int         wr_cycles [$];
    int         ack_cnt [NREQ];
    int         ovf_cnt;
    int         cyc;

    // Reference model: owner = -1 when nobody holds the path
    int m_owner, m_rr, m_sent, m_gid;
    bit m_tag, m_ovf;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] tag_of(input int id);
        logic [7:0] t;
        t = TAG_BASE;
        t[IDW-1:0] = IDW'(id);
        return t;
    endfunction

    task automatic push(input int i, input logic [7:0] b, input logic l);
        src[i][tl[i] % 64] = {l, b};
        tl[i]++;
    endtask

    task automatic clear_all();
        for (int i = 0; i < NREQ; i++) begin
            hd[i] = 0; tl[i] = 0; en[i] = 1'b1; ack_cnt[i] = 0;
        end
        out_log.delete();
        wr_cycles.delete();
        ovf_cnt = 0; cyc = 0; tx_full_drv = 1'b0;
        m_owner = -1; m_rr = NREQ - 1; m_sent = 0; m_gid = 0; m_tag = 1'b0; m_ovf = 1'b0;
        bus.req = '0; bus.last = '0; bus.din = '0; bus.tx_full = 1'b0;
    endtask

    task automatic do_reset();
        clear_all();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wr_uart", bus.wr_uart, 0);
        chk("rst_ack", bus.ack, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_grant", bus.grant_id, 0);
        chk("rst_ovf", bus.ovf_tick, 0);
        chk("rst_wdata", bus.w_data, 0);
        reset = 1'b0;
    endtask

    // One clock: drive sources, check DUT against the model mid-cycle, advance the model.
    task automatic cycle();
        logic [NREQ-1:0]      r, l, exp_ack;
        logic [NREQ*DBIT-1:0] d;
        logic                 exp_wr;
        logic [7:0]           exp_data;
        r = '0; l = '0; d = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (en[i] && hd[i] != tl[i]) begin
                r[i] = 1'b1;
                l[i] = src[i][hd[i] % 64][8];
                d[i*DBIT +: DBIT] = src[i][hd[i] % 64][7:0];
            end else begin
                l[i] = 1'($urandom_range(1));
                d[i*DBIT +: DBIT] = 8'($urandom);
            end
        end
        bus.req = r; bus.last = l; bus.din = d; bus.tx_full = tx_full_drv;
        @(negedge clk);
        exp_wr = 1'b0; exp_data = 8'h00; exp_ack = '0;
        if (m_owner >= 0 && m_tag) begin
            exp_wr = !tx_full_drv;
            exp_data = tag_of(m_owner);
        end else if (m_owner >= 0) begin
            exp_wr = r[m_owner] && !tx_full_drv;
            exp_data = d[m_owner*DBIT +: DBIT];
            exp_ack[m_owner] = exp_wr;
        end
        chk("wr_uart", bus.wr_uart, exp_wr);
        chk("ack", bus.ack, exp_ack);
        if (exp_wr) chk("w_data", bus.w_data, exp_data);
        chk("busy", bus.busy, (m_owner >= 0));
        chk("grant_id", bus.grant_id, m_gid);
        chk("ovf_tick", bus.ovf_tick, m_ovf);
        if (bus.wr_uart) begin
            out_log.push_back(bus.w_data);
            wr_cycles.push_back(cyc);
        end
        for (int i = 0; i < NREQ; i++) if (bus.ack[i]) ack_cnt[i]++;
        if (bus.ovf_tick) ovf_cnt++;
        m_ovf = 1'b0;
        if (m_owner < 0) begin
            for (int k = 1; k <= NREQ; k++) begin
                if (r[(m_rr + k) % NREQ]) begin
                    m_owner = (m_rr + k) % NREQ;
                    m_gid = m_owner; m_tag = (TAG_EN != 0); m_sent = 0;
                    break;
                end
            end
        end else if (m_tag) begin
            if (exp_wr) m_tag = 1'b0;
        end else if (exp_wr) begin
            hd[m_owner]++;
            m_sent++;
            if (l[m_owner] || m_sent == MAX_LEN) begin
                m_ovf = !l[m_owner];
                m_rr = m_owner;
                m_owner = -1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_until(input int n, input int budget, input string tag);
        int b;
        b = 0;
        while (out_log.size() < n && b < budget) begin
            cycle();
            b++;
        end
        if (out_log.size() < n) chk({tag, "_timeout"}, out_log.size(), n);
    endtask

    task automatic chk_log(input string tag, input logic [7:0] exp [$]);
        chk({tag, "_len"}, out_log.size(), exp.size());
        for (int i = 0; i < exp.size() && i < out_log.size(); i++)
            chk(tag, out_log[i], exp[i]);
    endtask

    initial begin
        logic [7:0] exp [$];
        int sz;

        // Single packet from requester 2
        do_reset();
        push(2, 8'h11, 1'b0); push(2, 8'h22, 1'b0); push(2, 8'h33, 1'b1);
        run_until(4, 20, "t1");
        exp = '{8'hA2, 8'h11, 8'h22, 8'h33};
        chk_log("t1_log", exp);
        if (wr_cycles.size() == 4) chk("t1_consec", wr_cycles[3] - wr_cycles[0], 3);
        chk("t1_acks", ack_cnt[2], 3);
        chk("t1_busy_end", bus.busy, 0);

        // Two contending requesters with 1-byte packets alternate
        do_reset();
        for (int p = 0; p < 3; p++) begin
            push(0, 8'(8'h10 + p), 1'b1);
            push(3, 8'(8'h30 + p), 1'b1);
        end
        run_until(12, 60, "t2");
        exp = '{8'hA0, 8'h10, 8'hA3, 8'h30, 8'hA0, 8'h11, 8'hA3, 8'h31, 8'hA0, 8'h12, 8'hA3, 8'h32};
        chk_log("t2_log", exp);

        // FIFO full stalls a packet without loss or duplication
        do_reset();
        push(1, 8'h51, 1'b0); push(1, 8'h52, 1'b0); push(1, 8'h53, 1'b1);
        run_until(2, 10, "t3a");
        tx_full_drv = 1'b1;
        sz = out_log.size();
        repeat (5) cycle();
        chk("t3_stall_writes", out_log.size(), sz);
        chk("t3_stall_acks", ack_cnt[1], 1);
        tx_full_drv = 1'b0;
        cycle();
        chk("t3_resume_len", out_log.size(), sz + 1);
        if (out_log.size() > 0) chk("t3_resume_byte", out_log[out_log.size()-1], 8'h52);
        run_until(4, 10, "t3b");
        exp = '{8'hA1, 8'h51, 8'h52, 8'h53};
        chk_log("t3_log", exp);

        // Length limit cuts the packet and re-arbitrates to the same sole requester
        do_reset();
        for (int i = 0; i < 6; i++) push(1, 8'(8'hC0 + i), 1'b0);
        run_until(8, 30, "t4");
        repeat (3) cycle();
        exp = '{8'hA1, 8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hA1, 8'hC4, 8'hC5};
        chk_log("t4_log", exp);
        chk("t4_ovf_cnt", ovf_cnt, 1);
        chk("t4_busy_hold", bus.busy, 1);

        // Owner pauses mid-packet while another requester waits
        do_reset();
        push(2, 8'h61, 1'b0); push(2, 8'h62, 1'b0); push(2, 8'h63, 1'b0); push(2, 8'h64, 1'b1);
        run_until(2, 10, "t5a");
        en[2] = 1'b0;
        push(0, 8'h70, 1'b1);
        sz = out_log.size();
        repeat (10) cycle();
        chk("t5_hold_writes", out_log.size(), sz);
        chk("t5_hold_grant", bus.grant_id, 2);
        chk("t5_hold_ack0", ack_cnt[0], 0);
        en[2] = 1'b1;
        run_until(7, 20, "t5b");
        exp = '{8'hA2, 8'h61, 8'h62, 8'h63, 8'h64, 8'hA0, 8'h70};
        chk_log("t5_log", exp);

        // Reset mid-packet abandons it at once
        do_reset();
        push(2, 8'h81, 1'b0); push(2, 8'h82, 1'b1);
        run_until(1, 10, "t6a");
        reset = 1'b1;
        #1;
        chk("t6_rst_wr", bus.wr_uart, 0);
        chk("t6_rst_busy", bus.busy, 0);
        chk("t6_rst_grant", bus.grant_id, 0);
        @(posedge clk);
        #1;
        clear_all();
        reset = 1'b0;
        push(3, 8'h93, 1'b1);
        push(1, 8'h91, 1'b1);
        run_until(4, 20, "t6b");
        exp = '{8'hA1, 8'h91, 8'hA3, 8'h93};
        chk_log("t6_log", exp);

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 800; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (hd[i] == tl[i] && $urandom_range(99) < 15) begin
                    int len;
                    len = int'($urandom_range(6, 1));
                    for (int b = 0; b < len; b++) push(i, 8'($urandom), b == len - 1);
                end
                if ($urandom_range(99) < 10) en[i] = !en[i];
            end
            tx_full_drv = ($urandom_range(3) == 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmit path (tx FIFO write side: wr_uart/w_data/tx_full) among NREQ byte-stream requesters.
- Round-robin arbitration at packet granularity: once granted, a requester owns the path until its last byte is accepted or the length limit forces release.
- Each packet is optionally prefixed with a tag byte carrying the requester id, so the far end can demultiplex the streams.

Parameters:
- NREQ, 4, number of requesters
- IDW, 2, requester id width (log2 NREQ)
- DBIT, 8, data byte width; must match the UART DBIT
- TAG_EN, 1, 1 = emit tag byte before each packet; 0 = no tag
- TAG_BASE, 8'hA0, tag byte = TAG_BASE with low IDW bits replaced by the granted id
- MAX_LEN, 64, maximum data bytes per packet, not counting the tag
- LEN_W, 7, byte counter width; must satisfy 2**LEN_W > MAX_LEN

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- req  in  NREQ  per-requester valid: byte din[i] is ready to send
- last  in  NREQ  per-requester end-of-packet flag; qualified by req[i]
- din  in  NREQ*DBIT  requester i data at din[i*DBIT +: DBIT]
- ack  out  NREQ  one-cycle pulse: byte of requester i was written this cycle
- tx_full  in  1  from UART tx FIFO; no write may occur while high
- wr_uart  out  1  write strobe to UART tx FIFO
- w_data  out  DBIT  data to UART tx FIFO
- busy  out  1  high while a packet is owned (state TAG or DATA)
- grant_id  out  IDW  id of the current or most recent owner
- ovf_tick  out  1  one-cycle pulse when a packet is cut at MAX_LEN

Behaviour:
- Reset (async, while high):
  - State = IDLE; wr_uart, ack, busy, ovf_tick = 0; grant_id = 0.
  - w_data = 0; byte counter = 0; rr pointer = NREQ-1, so req[0] has first priority.
- Registered state: state, grant_id, rr pointer, byte counter.
- Combinational outputs: wr_uart, w_data and ack are combinational from the registered state plus req/last/din/tx_full (zero latency). ovf_tick is registered.
- Round-robin search order is ptr+1, ptr+2, ... wrapping modulo NREQ.
- IDLE:
  - If any req is high, select the first requester in search order.
  - Load grant_id and clear the counter.
  - Next state is TAG if TAG_EN = 1, otherwise DATA.
  - No write occurs in the IDLE cycle, so arbitration costs 1 cycle.
- TAG:
  - w_data = tag byte; wr_uart = !tx_full; ack stays 0.
  - On write, go to DATA. While tx_full, hold.
- DATA:
  - w_data = din[grant_id]; wr_uart = req[grant_id] & !tx_full; ack[grant_id] = wr_uart.
  - Each write increments the counter.
  - If the write has last[grant_id] = 1, or the counter reaches MAX_LEN on this write: ptr <= grant_id and go to IDLE.
  - If the cut was due to the length limit and last = 0, pulse ovf_tick on the next cycle.
- Requester drops req mid-packet: ownership is held and no write occurs; the requester keeps the path until it resumes.
- Simultaneous requests: only the round-robin winner is granted; others wait with ack = 0.
- Back-to-back packets: one IDLE cycle between packets; the next winner is the first requester after the previous owner in search order.
- Only the owner is ever acked; ack is one-hot or zero.
- req/last of non-owners are ignored.
- Reset asserted mid-packet: immediate return to reset values; any partially sent packet is abandoned.

Test Plan:
- TAG_EN = 1, req[2] sends 3 bytes 11,22,33 with last on 33, tx_full = 0 -> FIFO receives A2,11,22,33 on consecutive cycles; ack[2] is high for 3 cycles; busy drops after 33.
- req[0] and req[3] both held high with 1-byte packets -> order A0,x,A3,y,A0,...; each grant alternates; ack never on both at once.
- tx_full held high 5 cycles during DATA -> wr_uart = 0 and ack = 0 for those cycles; byte written on the first cycle tx_full = 0; no byte lost or duplicated.
- MAX_LEN = 4, req[1] streams with last = 0 -> tag plus exactly 4 bytes written; ovf_tick pulses once; IDLE reached; re-arbitration gives req[1] a new tag A1 if it is the only requester.
- Owner deasserts req for 10 cycles mid-packet while req[0] is high -> no writes and no grant change; resumes when owner reasserts.
- Reset pulsed after the tag byte -> wr_uart = 0, busy = 0, grant_id = 0 immediately; first grant after release goes to the lowest active index.
